// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants, state type and channel-finder helper for the mux scanner
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic logic [SEL_W:0] next_ch(input logic [NUM_CH-1:0] mask, input int from);
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i > from && mask[i]) next_ch = {1'b1, SEL_W'(i)};
  endfunction
endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: lowest enabled channel strictly above cur, with a found flag
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              valid
);
  assign {valid, nxt} = next_ch(mask, int'(cur));
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives a 4:1 mux through enabled channels and samples its output per channel
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] data_in_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic              mux_out_i,
  output logic [NUM_CH-1:0] data_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [NUM_CH-1:0] sample_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int CW = $clog2(DWELL + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_CH-1:0] mask, mask_n, data_n, sample_n;
  logic [SEL_W-1:0] sel_n, nxt;
  logic [SEL_W:0] first;
  logic busy_n, done_n, nxt_valid, dwell_end;
  mux_scan_next_ch u_next (.mask(mask), .cur(sel_o), .nxt(nxt), .valid(nxt_valid));
  assign first = next_ch(ch_mask_i, -1);
  assign dwell_end = cnt == CW'(DWELL - 1);
  // mux output is only trusted on the last dwell cycle; earlier cycles cover settling
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mask_n = mask;
    data_n = data_o;
    sel_n = sel_o;
    sample_n = sample_o;
    busy_n = busy_o;
    done_n = 1'b0;
    if (state == SCAN) begin
      cnt_n = dwell_end ? '0 : cnt + CW'(1);
      if (dwell_end) begin
        sample_n[sel_o] = mux_out_i;
        sel_n = nxt_valid ? nxt : sel_o;
        state_n = nxt_valid ? SCAN : DONE;
        busy_n = nxt_valid;
        done_n = !nxt_valid;
      end
    end else if (start_i) begin
      data_n = data_in_i;
      mask_n = ch_mask_i;
      sample_n = '0;
      cnt_n = '0;
      sel_n = first[SEL_W] ? first[SEL_W-1:0] : sel_o;
      state_n = first[SEL_W] ? SCAN : DONE;
      busy_n = first[SEL_W];
      done_n = !first[SEL_W];
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      data_o <= '0;
      sel_o <= '0;
      sample_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mask <= mask_n;
      data_o <= data_n;
      sel_o <= sel_n;
      sample_o <= sample_n;
      busy_o <= busy_n;
      done_o <= done_n;
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench running DWELL=4 and DWELL=1 scanners side by side on shared stimulus
module tb_mux_scan_ctrl;
  localparam int DW [2] = '{4, 1};
  typedef struct {
    int d;
    logic [3:0] s;
    logic [3:0] data;
  } exp_t;
  logic clk = 0, rst = 0, start = 0;
  logic [3:0] din = 0, cmask = 0;
  logic [3:0] data_o [2];
  logic [1:0] sel_o [2];
  logic [3:0] sample_o [2];
  logic busy_o [2], done_o [2], mux_out [2];
  exp_t sb0[$], sb1[$];
  int last_d [2] = '{-1, -1};
  int ws [2] = '{0, 0};
  int we [2] = '{0, 0};
  logic [3:0] cur_mask [2] = '{4'd0, 4'd0};
  int edge_n = 0, pass_n = 0, total_n = 0;
  assign mux_out[0] = data_o[0][sel_o[0]];
  assign mux_out[1] = data_o[1][sel_o[1]];
  mux_scan_ctrl #(.DWELL(4)) u_d4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_in_i(din), .ch_mask_i(cmask),
    .mux_out_i(mux_out[0]), .data_o(data_o[0]), .sel_o(sel_o[0]), .sample_o(sample_o[0]),
    .busy_o(busy_o[0]), .done_o(done_o[0])
  );
  mux_scan_ctrl #(.DWELL(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_in_i(din), .ch_mask_i(cmask),
    .mux_out_i(mux_out[1]), .data_o(data_o[1]), .sel_o(sel_o[1]), .sample_o(sample_o[1]),
    .busy_o(busy_o[1]), .done_o(done_o[1])
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s dut%0d: got %b, expected %b (edge %0d)", name, k, act, exp, edge_n);
  endtask
  task automatic mon(input int k);
    exp_t h;
    logic has;
    has = (k == 0) ? sb0.size() > 0 : sb1.size() > 0;
    if (has) begin
      if (k == 0) h = sb0[0];
      else h = sb1[0];
    end
    chk("busy", k, {3'b0, busy_o[k]}, {3'b0, edge_n >= ws[k] && edge_n < we[k]});
    if (busy_o[k]) chk("sel_enabled", k, {3'b0, cur_mask[k][sel_o[k]]}, 4'd1);
    chk("done", k, {3'b0, done_o[k]}, {3'b0, has && h.d == edge_n});
    if (has && h.d <= edge_n) begin
      if (h.d == edge_n) begin
        chk("sample", k, sample_o[k], h.s);
        chk("data", k, data_o[k], h.data);
      end
      if (k == 0) void'(sb0.pop_front());
      else void'(sb1.pop_front());
    end
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic issue(input logic [3:0] d, input logic [3:0] m);
    int x, n, dd;
    exp_t e;
    x = edge_n + 1;
    n = $countones(m);
    for (int k = 0; k < 2; k++) begin
      if (x > last_d[k]) begin
        dd = x + n * DW[k];
        e.d = dd;
        e.s = d & m;
        e.data = d;
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
        ws[k] = x;
        we[k] = dd;
        last_d[k] = dd;
        cur_mask[k] = m;
      end
    end
    start = 1;
    din = d;
    cmask = m;
    cyc(1);
    start = 0;
    din = 4'($urandom);
    cmask = 4'($urandom);
  endtask
  task automatic do_reset();
    #1 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_data", k, data_o[k], 4'd0);
      chk("rst_sel", k, {2'b0, sel_o[k]}, 4'd0);
      chk("rst_sample", k, sample_o[k], 4'd0);
      chk("rst_busy", k, {3'b0, busy_o[k]}, 4'd0);
      chk("rst_done", k, {3'b0, done_o[k]}, 4'd0);
      last_d[k] = -1;
      ws[k] = 0;
      we[k] = 0;
    end
    sb0.delete();
    sb1.delete();
    cyc(2);
    rst = 0;
  endtask
  task automatic drain();
    int lim;
    lim = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && lim < 3000) begin
      cyc(1);
      lim++;
    end
    cyc(1);
    total_n++;
    if (sb0.size() == 0 && sb1.size() == 0) pass_n++;
    else $display("FAIL drain_timeout: pending %0d/%0d, expected 0/0", sb0.size(), sb1.size());
  endtask
  initial begin
    int x0;
    #2;
    do_reset();
    cyc(1);
    issue(4'b1010, 4'b1111);
    drain();
    issue(4'b1111, 4'b0101);
    drain();
    issue(4'b1011, 4'b0000);
    drain();
    issue(4'b0110, 4'b1111);
    cyc(2);
    issue(4'b1001, 4'b1111);
    drain();
    issue(4'b1111, 4'b1111);
    x0 = edge_n;
    while (edge_n < x0 + 5) cyc(1);
    do_reset();
    cyc(1);
    issue(4'b0011, 4'b1111);
    drain();
    issue(4'b1010, 4'b1111);
    while (edge_n < last_d[1]) cyc(1);
    issue(4'b1100, 4'b1100);
    drain();
    repeat (40) begin
      issue(4'($urandom), 4'($urandom));
      cyc($urandom_range(0, 20));
    end
    drain();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
